// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA controller: FSM state encoding,
// transfer mode values and the default word width.
package dma_pkg;

    localparam int unsigned DEF_WORD_SIZE = 16;

    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_STEAL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETUP   = 3'd2,
        ST_XFER    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } dma_state_e;

endpackage : dma_pkg

// File: rtl/dma_engine.sv
// Block-transfer DMA controller: BR/BG bus handshake, per-grant device setup,
// optional cycle stealing and retry of the in-flight word after preemption.
module dma_engine
    import dma_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
    parameter int unsigned LEN_WIDTH    = 6,
    parameter int unsigned SETUP_CYCLES = 6,
    parameter int unsigned BURST_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 startdma,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [WORD_SIZE-1:0] address,
    input  logic                 mode,
    input  logic                 BG,
    output logic                 BR,
    output logic                 use_bus,
    output logic [WORD_SIZE-1:0] o_address,
    output logic [LEN_WIDTH-1:0] idx,
    output logic                 busy,
    output logic                 interrupt
);

    localparam int unsigned SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int unsigned BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);

    dma_state_e           state_q, state_d;
    logic                 br_q, br_d;
    logic                 use_bus_q, use_bus_d;
    logic                 irq_q, irq_d;
    logic                 last_q, last_d;
    logic                 mode_q, mode_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [WORD_SIZE-1:0] base_q, base_d;
    logic [SETUP_W-1:0]   setup_q, setup_d;
    logic [BURST_W-1:0]   burst_q, burst_d;

    // Next-state and next-output logic; everything holds unless a transition says otherwise.
    always_comb begin
        state_d   = state_q;
        br_d      = br_q;
        use_bus_d = use_bus_q;
        irq_d     = 1'b0;
        last_d    = last_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        len_d     = len_q;
        base_d    = base_q;
        setup_d   = setup_q;
        burst_d   = burst_q;

        case (state_q)
            ST_IDLE: begin
                if (startdma) begin
                    if (length != '0) begin
                        len_d   = length;
                        base_d  = address;
                        mode_d  = mode;
                        idx_d   = '0;
                        last_d  = 1'b0;
                        br_d    = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        irq_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (BG) begin
                    setup_d = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!BG) begin
                    use_bus_d = 1'b0;
                    state_d   = ST_REQ;
                end else if (setup_q == SETUP_LAST) begin
                    use_bus_d = 1'b1;
                    burst_d   = '0;
                    state_d   = ST_XFER;
                end else begin
                    setup_d = setup_q + SETUP_W'(1);
                end
            end
            ST_XFER: begin
                // Preemption leaves idx alone so the word in flight is retried.
                if (!BG) begin
                    use_bus_d = 1'b0;
                    state_d   = ST_REQ;
                end else if (idx_q == LEN_WIDTH'(len_q - LEN_WIDTH'(1))) begin
                    use_bus_d = 1'b0;
                    br_d      = 1'b0;
                    last_d    = 1'b1;
                    state_d   = ST_RELEASE;
                end else if (mode_q == MODE_STEAL && burst_q == BURST_LAST) begin
                    idx_d     = idx_q + LEN_WIDTH'(1);
                    use_bus_d = 1'b0;
                    br_d      = 1'b0;
                    state_d   = ST_RELEASE;
                end else begin
                    idx_d   = idx_q + LEN_WIDTH'(1);
                    burst_d = burst_q + BURST_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!BG) begin
                    if (last_q) begin
                        irq_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        br_d    = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            br_q      <= 1'b0;
            use_bus_q <= 1'b0;
            irq_q     <= 1'b0;
            last_q    <= 1'b0;
            mode_q    <= MODE_BURST;
            idx_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            setup_q   <= '0;
            burst_q   <= '0;
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            use_bus_q <= use_bus_d;
            irq_q     <= irq_d;
            last_q    <= last_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            base_q    <= base_d;
            setup_q   <= setup_d;
            burst_q   <= burst_d;
        end
    end

    assign BR        = br_q;
    assign use_bus   = use_bus_q;
    assign interrupt = irq_q;
    assign idx       = idx_q;
    assign busy      = (state_q != ST_IDLE);
    assign o_address = base_q + WORD_SIZE'(idx_q);

endmodule : dma_engine

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: burst, cycle-steal, zero length, preemption,
// address wrap, reset abort and start-while-busy.
module tb_dma_engine;
    import dma_pkg::*;

    localparam int unsigned WS  = 16;
    localparam int unsigned LW  = 6;
    localparam int unsigned SC  = 6;
    localparam int unsigned BLN = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          startdma;
    logic [LW-1:0] length;
    logic [WS-1:0] address;
    logic          mode;
    logic          BG;
    logic          BR;
    logic          use_bus;
    logic [WS-1:0] o_address;
    logic [LW-1:0] idx;
    logic          busy;
    logic          interrupt;

    int checks   = 0;
    int failures = 0;

    dma_engine #(
        .WORD_SIZE   (WS),
        .LEN_WIDTH   (LW),
        .SETUP_CYCLES(SC),
        .BURST_LEN   (BLN)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .startdma (startdma),
        .length   (length),
        .address  (address),
        .mode     (mode),
        .BG       (BG),
        .BR       (BR),
        .use_bus  (use_bus),
        .o_address(o_address),
        .idx      (idx),
        .busy     (busy),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [LW-1:0] len, input logic [WS-1:0] addr, input logic md);
        startdma = 1'b1;
        length   = len;
        address  = addr;
        mode     = md;
        tick();
        startdma = 1'b0;
        chk("start_br", BR, 1);
        chk("start_busy", busy, 1);
        chk("start_use_bus", use_bus, 0);
    endtask

    // Grant the bus, sit through setup, then expect nwords contiguous words.
    task automatic run_grant(input string tag, input int first, input int nwords,
                             input logic [WS-1:0] base, input int idx_after);
        logic [WS-1:0] ea;
        BG = 1'b1;
        repeat (SC) tick();
        chk({tag, "_setup_use_bus"}, use_bus, 0);
        for (int w = 0; w < nwords; w++) begin
            tick();
            ea = base + WS'(first + w);
            chk({tag, "_xfer_use_bus"}, use_bus, 1);
            chk({tag, "_xfer_addr"}, o_address, ea);
            chk({tag, "_xfer_idx"}, idx, first + w);
        end
        tick();
        chk({tag, "_rel_use_bus"}, use_bus, 0);
        chk({tag, "_rel_br"}, BR, 0);
        chk({tag, "_rel_idx"}, idx, idx_after);
        chk({tag, "_rel_irq"}, interrupt, 0);
    endtask

    task automatic finish_block(input string tag);
        BG = 1'b0;
        tick();
        chk({tag, "_irq_high"}, interrupt, 1);
        chk({tag, "_irq_busy"}, busy, 1);
        chk({tag, "_irq_br"}, BR, 0);
        tick();
        chk({tag, "_irq_low"}, interrupt, 0);
        chk({tag, "_end_idx"}, idx, 0);
        chk({tag, "_end_busy"}, busy, 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        startdma = 1'b0;
        length   = '0;
        address  = '0;
        mode     = MODE_BURST;
        BG       = 1'b0;
        #3;
        chk("rst_br", BR, 0);
        chk("rst_use_bus", use_bus, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", interrupt, 0);
        chk("rst_idx", idx, 0);
        chk("rst_addr", o_address, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Burst, 12 words from 0x0100.
        start_block(6'd12, 16'h0100, MODE_BURST);
        run_grant("burst", 0, 12, 16'h0100, 11);
        finish_block("burst");

        // Cycle steal, 10 words from 0x0200: grants of 4, 4, 2.
        start_block(6'd10, 16'h0200, MODE_STEAL);
        run_grant("steal_g0", 0, 4, 16'h0200, 4);
        BG = 1'b0;
        tick();
        chk("steal_g0_rereq_br", BR, 1);
        chk("steal_g0_rereq_irq", interrupt, 0);
        run_grant("steal_g1", 4, 4, 16'h0200, 8);
        BG = 1'b0;
        tick();
        chk("steal_g1_rereq_br", BR, 1);
        chk("steal_g1_rereq_irq", interrupt, 0);
        run_grant("steal_g2", 8, 2, 16'h0200, 9);
        finish_block("steal");

        // Zero length: immediate interrupt, no bus request.
        startdma = 1'b1;
        length   = 6'd0;
        address  = 16'h1234;
        tick();
        startdma = 1'b0;
        chk("zero_irq", interrupt, 1);
        chk("zero_br", BR, 0);
        chk("zero_use_bus", use_bus, 0);
        chk("zero_busy", busy, 1);
        tick();
        chk("zero_irq_low", interrupt, 0);
        chk("zero_br_low", BR, 0);
        chk("zero_busy_low", busy, 0);

        // Preemption after idx 0..3 are presented; idx 3 is retried.
        start_block(6'd8, 16'h0300, MODE_BURST);
        BG = 1'b1;
        repeat (SC) tick();
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("pre_use_bus", use_bus, 1);
            chk("pre_idx", idx, w);
        end
        BG = 1'b0;
        tick();
        chk("pre_drop_use_bus", use_bus, 0);
        chk("pre_drop_br", BR, 1);
        chk("pre_drop_idx", idx, 3);
        tick();
        chk("pre_wait_use_bus", use_bus, 0);
        run_grant("pre_resume", 3, 5, 16'h0300, 7);
        finish_block("pre");

        // Address wrap past 0xFFFF.
        start_block(6'd4, 16'hFFFE, MODE_BURST);
        run_grant("wrap", 0, 4, 16'hFFFE, 3);
        finish_block("wrap");

        // Asynchronous reset in the middle of a transfer.
        start_block(6'd6, 16'h0500, MODE_BURST);
        BG = 1'b1;
        repeat (SC + 2) tick();
        chk("abort_pre_use_bus", use_bus, 1);
        chk("abort_pre_idx", idx, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_br", BR, 0);
        chk("abort_use_bus", use_bus, 0);
        chk("abort_busy", busy, 0);
        chk("abort_idx", idx, 0);
        chk("abort_addr", o_address, 0);
        chk("abort_irq", interrupt, 0);
        BG = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            chk("abort_no_irq", interrupt, 0);
            chk("abort_idle", busy, 0);
        end

        // Start requests while busy are ignored.
        start_block(6'd3, 16'h0400, MODE_BURST);
        startdma = 1'b1;
        length   = 6'd9;
        address  = 16'h0999;
        mode     = MODE_STEAL;
        tick();
        chk("ign_req_br", BR, 1);
        startdma = 1'b0;
        run_grant("ign", 0, 3, 16'h0400, 2);
        finish_block("ign");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dma_engine
